fifo_level: RTL and testbench
=============================

// Module: fifo_level
// PURPOSE
//  Parametrised synchronous FIFO, successor to the basic 64x16 queue.
//  Adds generic width/depth, fill-level output, almost-full/almost-empty thresholds,
//  synchronous flush, full-with-read pass-through and sticky overflow/underflow flags.
//  Sits between byte producers/consumers (UART RX/TX paths) in the single clk domain.
// PARAMETERS
//  WIDTH    16  data width in bits
//  ADDR_W    6  log2(depth); DEPTH = 2**ADDR_W entries
//  AF_LVL   56  almost_full asserted when level >= AF_LVL (1..DEPTH)
//  AE_LVL    8  almost_empty asserted when level <= AE_LVL (0..DEPTH-1)
// PORTS
//  clk          in   1         rising-edge clock
//  reset_n      in   1         synchronous, active-low reset
//  flush        in   1         discard all contents (sync)
//  wr_port      in   WIDTH     write data
//  wr_req       in   1         push request
//  q_full       out  1         level == DEPTH
//  rd_port      out  WIDTH     head entry (first-word fall-through, valid when !q_empty)
//  rd_done      in   1         pop head entry
//  q_empty      out  1         level == 0
//  level        out  ADDR_W+1  entries held, 0..DEPTH
//  almost_full  out  1         level >= AF_LVL
//  almost_empty out  1         level <= AE_LVL
//  overflow     out  1         sticky: wr_req rejected
//  underflow    out  1         sticky: rd_done while empty
//  err_clr      in   1         clears overflow/underflow
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. On clk edge with reset_n=0: wr_ptr=rd_ptr=0,
//    overflow=underflow=0 -> q_empty=1, q_full=0, level=0, almost_empty=1, almost_full=0.
//    RAM contents not reset; rd_port undefined while empty.
//  - Pointers ADDR_W+1 bits; MSB is wrap bit. level = wr_ptr - rd_ptr (mod 2**(ADDR_W+1)).
//    Flags/level are combinational from registered pointers (no extra latency).
//  - Push accepted: wr_req && (!q_full || rd_done). Write lands at wr_ptr[ADDR_W-1:0], wr_ptr++.
//  - Pop accepted: rd_done && !q_empty. rd_ptr++. rd_port = mem[rd_ptr[ADDR_W-1:0]] (async read).
//  - Full + wr_req + rd_done: both accepted, level stays DEPTH, no overflow.
//  - Empty + wr_req + rd_done: push accepted, pop rejected, underflow set; written data
//    visible on rd_port the following cycle (1-cycle write-to-read latency).
//  - overflow set when wr_req && q_full && !rd_done; underflow set when rd_done && q_empty.
//    Both hold until err_clr=1 or reset; a set event in the same cycle as err_clr wins.
//  - flush (priority over push/pop same cycle): rd_ptr <= wr_ptr; flags unaffected.
//    reset_n=0 overrides flush. Reset mid-stream drops all data, no error flags.
//  - Pointer wrap at 2**(ADDR_W+1) is natural modulo; no special case.
// STRUCTURE
//  - fifo_pkg: pointer/level width function (ADDR_W+1), threshold range-check macros.
//  - Sub-module fifo_ram: DEPTH x WIDTH, 1 sync write port, 1 async read port.
//  - Top holds pointers, accept logic, level/threshold compare, sticky error regs.
// TESTING (WIDTH=8, ADDR_W=2, AF_LVL=3, AE_LVL=1)
//  1 reset_n=0 1 clk -> q_empty=1, level=0, almost_empty=1, overflow=underflow=0.
//  2 push 0xA1..0xA4 -> level 1,2,3,4; almost_empty drops at level 2, almost_full at 3,
//    q_full at 4; pop 4 -> rd_port 0xA1,0xA2,0xA3,0xA4 in order, q_empty=1.
//  3 full, push 0xB5 without rd_done -> overflow=1, level=4, contents unchanged; err_clr -> 0.
//  4 full, wr_req+rd_done with 0xC0 -> rd_port advances, level=4, overflow stays 0; drain
//    yields 0xC0 last.
//  5 empty, rd_done+wr_req 0x55 -> underflow=1, level=1, rd_port=0x55 next cycle.
//  6 push 3, flush with wr_req=1 -> level=0, q_empty=1, push ignored; 10 push/pop
//    cycles wrap pointers past 7 with data order preserved.

Source files
------------

// File: rtl/fifo_level_pkg.sv
// Shared sizing helpers for the fifo_level slice.
package fifo_level_pkg;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 2 ** addr_w;
    endfunction

    // Legal threshold ranges: almost_full in 1..DEPTH, almost_empty in 0..DEPTH-1.
    function automatic bit af_lvl_ok(input int unsigned lvl, input int unsigned addr_w);
        return (lvl >= 1) && (lvl <= fifo_depth(addr_w));
    endfunction

    function automatic bit ae_lvl_ok(input int unsigned lvl, input int unsigned addr_w);
        return lvl < fifo_depth(addr_w);
    endfunction

endpackage

// File: rtl/fifo_level_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_level_ram #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_level.sv
// Parametrised synchronous FIFO with fill level, thresholds, flush and sticky error flags.
module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned AF_LVL = 56,
    parameter int unsigned AE_LVL = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [WIDTH-1:0]  wr_port,
    input  logic              wr_req,
    output logic              q_full,
    output logic [WIDTH-1:0]  rd_port,
    input  logic              rd_done,
    output logic              q_empty,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int unsigned PtrW = ptr_width(ADDR_W);
    localparam int unsigned Depth = fifo_depth(ADDR_W);
    localparam logic [PtrW-1:0] DepthLvl = PtrW'(Depth);
    localparam logic [PtrW-1:0] AfLvl    = PtrW'(AF_LVL);
    localparam logic [PtrW-1:0] AeLvl    = PtrW'(AE_LVL);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic [PtrW-1:0] lvl;
    logic            push_acc;
    logic            pop_acc;
    logic            ram_we;

    // Level and flags come straight from the registered pointers.
    always_comb begin
        lvl          = wr_ptr_q - rd_ptr_q;
        q_full       = (lvl == DepthLvl);
        q_empty      = (lvl == '0);
        almost_full  = (lvl >= AfLvl);
        almost_empty = (lvl <= AeLvl);
    end

    assign level     = lvl;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Accept logic; a read frees the slot a simultaneous write into a full queue needs.
    always_comb begin
        push_acc = wr_req && (!q_full || rd_done) && !flush;
        pop_acc  = rd_done && !q_empty && !flush;
        ram_we   = push_acc;
    end

    // Pointer next state; flush empties the queue by catching rd_ptr up to wr_ptr.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Sticky errors: a set event outranks err_clr in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush && wr_req && q_full && !rd_done) begin
            overflow_d = 1'b1;
        end
        if (!flush && rd_done && q_empty) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_level_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_port),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_port)
    );

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fifo_level;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AF_LVL = 3;
    localparam int unsigned AE_LVL = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic [WIDTH-1:0] wr_port;
    logic             wr_req;
    logic             q_full;
    logic [WIDTH-1:0] rd_port;
    logic             rd_done;
    logic             q_empty;
    logic [ADDR_W:0]  level;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    fifo_level #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .wr_port      (wr_port),
        .wr_req       (wr_req),
        .q_full       (q_full),
        .rd_port      (rd_port),
        .rd_done      (rd_done),
        .q_empty      (q_empty),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, sticky flags as bits.
    logic [WIDTH-1:0] model_q[$];
    bit               m_ovf;
    bit               m_udf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = model_q.size();
        check("level", 32'(level), 32'(sz));
        check("q_empty", 32'(q_empty), 32'(sz == 0));
        check("q_full", 32'(q_full), 32'(sz == DEPTH));
        check("almost_full", 32'(almost_full), 32'(sz >= AF_LVL));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE_LVL));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
        if (sz != 0) begin
            check("rd_port", 32'(rd_port), 32'(model_q[0]));
        end
    endtask

    // Applies one cycle of inputs, checks pre-edge outputs, then advances the model.
    task automatic step(input bit wr, input logic [WIDTH-1:0] wd, input bit rd,
                        input bit fl, input bit ec, input bit rst_n);
        bit full;
        bit empty;
        wr_req  = wr;
        wr_port = wd;
        rd_done = rd;
        flush   = fl;
        err_clr = ec;
        reset_n = rst_n;
        @(negedge clk);
        check_all();
        @(posedge clk);
        full  = (model_q.size() == DEPTH);
        empty = (model_q.size() == 0);
        if (!rst_n) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (fl) begin
            model_q.delete();
            if (ec) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            if (ec) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (wr && full && !rd) m_ovf = 1'b1;
            if (rd && empty) m_udf = 1'b1;
            if (rd && !empty) void'(model_q.pop_front());
            if (wr && (!full || rd)) model_q.push_back(wd);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        wr_req  = 1'b0;
        wr_port = '0;
        rd_done = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;

        // Reset state, then fill with A1..A4 and drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Overflow on full, then clear it.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        // Full pass-through with C0, then drain.
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Empty with simultaneous read and write.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Flush wins over a same-cycle push.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        // Steady push/pop to carry pointers through wrap.
        step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Randomized traffic with alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 400; i++) begin
            bit wr_heavy;
            wr_heavy = ((i / 40) % 2) == 0;
            step(($urandom_range(0, 99) < (wr_heavy ? 75 : 30)),
                 8'($urandom()),
                 ($urandom_range(0, 99) < (wr_heavy ? 30 : 75)),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) >= 1));
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
